// File: rtl/mem_arbiter.sv
// Arbitrates the byte-serial memory controller between instruction fetch and load/store.
// Round-robin grant, request fields registered for the whole transaction, flush discards fetches.
module mem_arbiter #(
  parameter bit LS_FIRST = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_data,
  input  logic        ls_r_nw,
  input  logic [2:0]  ls_type,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_data,
  output logic        mc_r_nw,
  output logic [2:0]  mc_type,
  output logic        mc_activate,
  input  logic [31:0] mc_data_out,
  input  logic        mc_data_available
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_ls_q, last_ls_d;
  logic        discard_q, discard_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [31:0] mc_data_q, mc_data_d;
  logic        mc_r_nw_q, mc_r_nw_d;
  logic [2:0]  mc_type_q, mc_type_d;

  logic elig_if, elig_ls, grant_ls, grant_if;

  // On a tie the requester that did not win last time gets the grant.
  assign elig_if  = if_req && !flush_in;
  assign elig_ls  = ls_req;
  assign grant_ls = elig_ls && (!elig_if || !last_ls_q);
  assign grant_if = elig_if && !grant_ls;

  always_comb begin
    state_d   = state_q;
    last_ls_d = last_ls_q;
    discard_d = discard_q;
    mc_addr_d = mc_addr_q;
    mc_data_d = mc_data_q;
    mc_r_nw_d = mc_r_nw_q;
    mc_type_d = mc_type_q;
    case (state_q)
      IDLE: begin
        if (grant_ls) begin
          state_d   = BUSY_LS;
          last_ls_d = 1'b1;
          mc_addr_d = ls_addr;
          mc_data_d = ls_data;
          mc_r_nw_d = ls_r_nw;
          mc_type_d = ls_type;
        end else if (grant_if) begin
          state_d   = BUSY_IF;
          last_ls_d = 1'b0;
          mc_addr_d = if_addr;
          mc_data_d = 32'h0;
          mc_r_nw_d = 1'b1;
          mc_type_d = 3'b000;
        end
      end
      BUSY_IF: begin
        // The controller cannot abort, so a flushed fetch runs on with its result dropped.
        if (flush_in) discard_d = 1'b1;
        if (mc_data_available) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end
      end
      BUSY_LS: begin
        if (mc_data_available) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      last_ls_q <= !LS_FIRST;
      discard_q <= 1'b0;
      mc_addr_q <= 32'h0;
      mc_data_q <= 32'h0;
      mc_r_nw_q <= 1'b0;
      mc_type_q <= 3'b000;
    end else if (rdy_in) begin
      state_q   <= state_d;
      last_ls_q <= last_ls_d;
      discard_q <= discard_d;
      mc_addr_q <= mc_addr_d;
      mc_data_q <= mc_data_d;
      mc_r_nw_q <= mc_r_nw_d;
      mc_type_q <= mc_type_d;
    end
  end

  assign mc_addr     = mc_addr_q;
  assign mc_data     = mc_data_q;
  assign mc_r_nw     = mc_r_nw_q;
  assign mc_type     = mc_type_q;
  assign mc_activate = (state_q != IDLE) && !mc_data_available;

  assign if_done  = (state_q == BUSY_IF) && mc_data_available && !discard_q && !flush_in;
  assign ls_done  = (state_q == BUSY_LS) && mc_data_available;
  assign if_data  = mc_data_out;
  assign ls_rdata = mc_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-modelled memory controller and a grant scoreboard.
module tb_mem_arbiter;
  localparam int LAT = 6;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        if_req, if_done, ls_req, ls_r_nw, ls_done;
  logic [31:0] if_addr, if_data, ls_addr, ls_data, ls_rdata;
  logic [2:0]  ls_type, mc_type;
  logic [31:0] mc_addr, mc_data, mc_data_out;
  logic        mc_r_nw, mc_activate, mc_data_available;

  int tests = 0;
  int fails = 0;
  int compl_cnt = 0;

  typedef struct {
    bit          is_ls;
    logic [31:0] addr;
    logic [31:0] data;
    logic        r_nw;
    logic [2:0]  typ;
    logic [31:0] rdata;
    bit          ifd;
    bit          lsd;
    int          act;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.LS_FIRST(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_data(ls_data), .ls_r_nw(ls_r_nw),
    .ls_type(ls_type), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mc_addr(mc_addr), .mc_data(mc_data), .mc_r_nw(mc_r_nw), .mc_type(mc_type),
    .mc_activate(mc_activate), .mc_data_out(mc_data_out),
    .mc_data_available(mc_data_available)
  );

  function automatic logic [31:0] mem_resp(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  // Controller model: completes LAT active cycles after activation, frozen by rdy_in.
  int   mc_cnt;
  logic mda;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mc_cnt <= 0;
      mda    <= 1'b0;
    end else if (rdy_in) begin
      mda <= 1'b0;
      if (mc_activate) begin
        if (mc_cnt == LAT - 1) begin
          mda    <= 1'b1;
          mc_cnt <= 0;
        end else begin
          mc_cnt <= mc_cnt + 1;
        end
      end
    end
  end
  assign mc_data_available = mda;
  assign mc_data_out       = mda ? mem_resp(mc_addr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_ls, input logic [31:0] addr, input logic [31:0] data,
                      input logic r_nw, input logic [2:0] typ, input bit ifd, input bit lsd,
                      input int act);
    exp_t e;
    e.is_ls = is_ls; e.addr = addr; e.data = data; e.r_nw = r_nw; e.typ = typ;
    e.rdata = mem_resp(addr); e.ifd = ifd; e.lsd = lsd; e.act = act;
    exp_q.push_back(e);
  endtask

  // Grant and completion monitor against the scoreboard.
  logic prev_act = 1'b0;
  int   act_cnt  = 0;
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_act = 1'b0;
      act_cnt  = 0;
    end else begin
      if (mc_activate && !prev_act) begin
        act_cnt = 0;
        if (exp_q.size() == 0) chk("unexpected_grant", 32'(mc_activate), 32'h0);
        else begin
          chk("grant_addr", mc_addr, exp_q[0].addr);
          chk("grant_data", mc_data, exp_q[0].data);
          chk("grant_rnw", 32'(mc_r_nw), 32'(exp_q[0].r_nw));
          chk("grant_type", 32'(mc_type), 32'(exp_q[0].typ));
        end
      end
      if (mc_activate) act_cnt++;
      if (mc_data_available) begin
        compl_cnt++;
        if (exp_q.size() == 0) chk("unexpected_completion", 32'(mc_data_available), 32'h0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("if_done", 32'(if_done), 32'(e.ifd));
          chk("ls_done", 32'(ls_done), 32'(e.lsd));
          chk("active_cycles", 32'(act_cnt), 32'(e.act));
          if (e.is_ls) chk("ls_rdata", ls_rdata, e.rdata);
          else if (e.ifd) chk("if_data", if_data, e.rdata);
        end
      end else begin
        chk("stray_done", {30'h0, if_done, ls_done}, 32'h0);
      end
      prev_act = mc_activate;
    end
  end

  task automatic wait_compl(input int target);
    int n = 0;
    while (compl_cnt < target && n < 200) begin
      @(negedge clk_in); #1;
      n++;
    end
    chk("completion_timeout", 32'(compl_cnt), 32'(target));
  endtask

  task automatic wait_act();
    int n = 0;
    while (!mc_activate && n < 50) begin
      @(negedge clk_in); #1;
      n++;
    end
    chk("activate_timeout", 32'(mc_activate), 32'h1);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(negedge clk_in); #1;
    @(negedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in); #1;
  endtask

  initial begin
    int base;
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_addr = 32'h0; ls_data = 32'h0; ls_r_nw = 1'b1; ls_type = 3'b000;
    #1;
    chk("rst_activate", 32'(mc_activate), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_ls_done", 32'(ls_done), 32'h0);
    chk("rst_mc_addr", mc_addr, 32'h0);
    chk("rst_mc_rnw", 32'(mc_r_nw), 32'h0);
    do_reset();

    // Lone fetch
    base = compl_cnt;
    push(1'b0, 32'h100, 32'h0, 1'b1, 3'b000, 1'b1, 1'b0, LAT);
    if_addr = 32'h100; if_req = 1'b1;
    wait_compl(base + 1);
    if_req = 1'b0;

    // Both held from reset: LS wins first, then alternation
    do_reset();
    if_addr = 32'h200;
    ls_addr = 32'h2000; ls_data = 32'h1234; ls_r_nw = 1'b1; ls_type = 3'b101;
    base = compl_cnt;
    push(1'b1, 32'h2000, 32'h1234, 1'b1, 3'b101, 1'b0, 1'b1, LAT);
    push(1'b0, 32'h200,  32'h0,    1'b1, 3'b000, 1'b1, 1'b0, LAT);
    push(1'b1, 32'h2000, 32'h1234, 1'b1, 3'b101, 1'b0, 1'b1, LAT);
    push(1'b0, 32'h200,  32'h0,    1'b1, 3'b000, 1'b1, 1'b0, LAT);
    if_req = 1'b1; ls_req = 1'b1;
    wait_compl(base + 4);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk_in); #1;

    // Byte store passes through untouched
    base = compl_cnt;
    ls_addr = 32'h30000; ls_data = 32'h41; ls_r_nw = 1'b0; ls_type = 3'b010;
    push(1'b1, 32'h30000, 32'h41, 1'b0, 3'b010, 1'b0, 1'b1, LAT);
    ls_req = 1'b1;
    wait_compl(base + 1);
    ls_req = 1'b0;
    @(negedge clk_in); #1;

    // Flush during a fetch; pending load follows
    base = compl_cnt;
    if_addr = 32'h400;
    ls_addr = 32'h500; ls_data = 32'h0; ls_r_nw = 1'b1; ls_type = 3'b000;
    push(1'b0, 32'h400, 32'h0, 1'b1, 3'b000, 1'b0, 1'b0, LAT);
    push(1'b1, 32'h500, 32'h0, 1'b1, 3'b000, 1'b0, 1'b1, LAT);
    if_req = 1'b1; ls_req = 1'b1;
    wait_act();
    @(negedge clk_in); #1;
    @(negedge clk_in); #1;
    flush_in = 1'b1;
    @(negedge clk_in); #1;
    flush_in = 1'b0; if_req = 1'b0;
    chk("flush_activate_held", 32'(mc_activate), 32'h1);
    wait_compl(base + 2);
    ls_req = 1'b0;
    @(negedge clk_in); #1;

    // rdy_in low for 5 cycles mid-transaction
    base = compl_cnt;
    ls_addr = 32'h600; ls_r_nw = 1'b1; ls_type = 3'b001;
    push(1'b1, 32'h600, 32'h0, 1'b1, 3'b001, 1'b0, 1'b1, LAT + 5);
    ls_req = 1'b1;
    wait_act();
    @(negedge clk_in); #1;
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in); #1;
      chk("freeze_activate", 32'(mc_activate), 32'h1);
      chk("freeze_addr", mc_addr, 32'h600);
    end
    rdy_in = 1'b1;
    wait_compl(base + 1);
    ls_req = 1'b0;
    @(negedge clk_in); #1;

    // Asynchronous reset in BUSY_LS
    base = compl_cnt;
    ls_addr = 32'h700; ls_type = 3'b000;
    push(1'b1, 32'h700, 32'h0, 1'b1, 3'b000, 1'b0, 1'b1, LAT);
    ls_req = 1'b1;
    wait_act();
    @(negedge clk_in); #1;
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst_activate", 32'(mc_activate), 32'h0);
    chk("async_rst_ls_done", 32'(ls_done), 32'h0);
    chk("async_rst_mc_addr", mc_addr, 32'h0);
    exp_q.delete();
    ls_req = 1'b0;
    @(negedge clk_in); #1;
    rst_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in); #1;
      chk("post_rst_idle", {30'h0, mc_activate, ls_done}, 32'h0);
    end
    chk("post_rst_completions", 32'(compl_cnt), 32'(base));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-serial memory controller between the instruction-fetch unit (IF, read-only, word) and the load/store unit (LS, read/write, typed).
- Grants one requester at a time, holds the request stable for the whole transaction and returns the result to the owner.
- Round-robin between the two requesters, with a flush path that discards in-flight fetches.
- Sits between the IF/LS units and the memory controller in the CPU top.

Parameters:
LS_FIRST, 1, requester that wins the first tie after reset (1: LS, 0: IF)

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global enable; low freezes all registered state
flush_in  input  1  branch mispredict; cancels pending or in-flight fetch
if_req  input  1  IF request valid; held with if_addr until if_done or flush
if_addr  input  32  fetch address
if_done  output  1  one-cycle pulse, if_data valid
if_data  output  32  fetched word
ls_req  input  1  LS request valid; held with fields until ls_done
ls_addr  input  32  load/store address
ls_data  input  32  store data
ls_r_nw  input  1  1 read, 0 write
ls_type  input  3  [1:0] 00 word/01 half/10 byte; [2] 1 unsigned
ls_done  output  1  one-cycle pulse; ls_rdata valid for reads
ls_rdata  output  32  extended load result
mc_addr  output  32  controller address
mc_data  output  32  controller write data
mc_r_nw  output  1  controller read/write select
mc_type  output  3  controller access type
mc_activate  output  1  controller request
mc_data_out  input  32  controller result
mc_data_available  input  1  controller completion pulse

Behaviour:
- States: IDLE, BUSY_IF, BUSY_LS. Registers: state, last_grant, discard, mc_addr/mc_data/mc_r_nw/mc_type.
- Reset (async): state=IDLE, last_grant=!LS_FIRST encoding (so LS_FIRST wins the first tie), discard=0, mc_* regs=0. if_done=ls_done=mc_activate=0.
- rdy_in=0: no register changes; combinational outputs still follow their equations.
- IDLE arbitration at the clock edge:
  - eligible_if = if_req && !flush_in; eligible_ls = ls_req.
  - Only one eligible: grant it.
  - Both eligible: grant the one not equal to last_grant.
  - On grant: latch fields into mc_* and update last_grant.
    - IF grant: mc_r_nw=1, mc_type=000, mc_data=0.
    - LS grant: ls_* fields copied as-is.
  - Next state is BUSY_IF or BUSY_LS.
- mc_activate = (state != IDLE) && !mc_data_available (combinational). This guarantees activate is low in the completion cycle. mc_* are register outputs, stable for the entire transaction.
- Completion: in a BUSY state with mc_data_available=1, return to IDLE next edge.
  - if_done = (state==BUSY_IF) && mc_data_available && !discard && !flush_in.
  - ls_done = (state==BUSY_LS) && mc_data_available.
  - if_data = ls_rdata = mc_data_out (pass-through, no added latency).
- Flush:
  - In IDLE, a flush blocks the IF grant in that cycle.
  - In BUSY_IF, flush sets discard=1; the transaction still runs to completion (the controller cannot abort) but its if_done is suppressed. discard clears on returning to IDLE.
  - LS is never affected by flush.
- Latency: request seen at edge N → mc_activate high from cycle N+1. Done in the cycle mc_data_available rises. At least one IDLE bubble between back-to-back transactions.
- A requester dropping req while BUSY for it (other than IF on flush) is illegal; the arbiter ignores the drop and completes.
- Reset asserted mid-transaction: immediate return to IDLE, no done pulse. The controller is reset by the same rst_in.

Test Plan:
- Reset, then if_req=1, if_addr=0x100 only → mc_addr=0x100, mc_r_nw=1, mc_type=000, mc_activate high until mc_data_available; if_done pulses once with if_data=mc_data_out=0xDEADBEEF; ls_done stays 0.
- Both requests held continuously from reset with LS_FIRST=1 → grant order LS, IF, LS, IF; each done pulses exactly once per grant, with one IDLE cycle between grants.
- LS store: ls_addr=0x30000, ls_data=0x41, ls_r_nw=0, ls_type=010 → mc_* carry those values unchanged; ls_done pulses on completion.
- flush_in pulsed 2 cycles into a BUSY_IF word fetch → mc_activate stays high until mc_data_available; if_done never pulses; the next pending ls_req is granted afterwards.
- rdy_in low for 5 cycles mid-transaction → state and mc_* frozen; completion resumes normally once rdy_in returns high.
- rst_in asserted asynchronously (between clock edges) in BUSY_LS → state=IDLE and mc_activate=0 immediately, no ls_done pulse.
